idex_dispatch: RTL and testbench
================================

Name: idex_dispatch

Overview:
- ID/EX pipeline stage between the decode stage and the per-unit reservation stations.
- Captures one decoded instruction per cycle: ex_unit, op, two source tag/value pairs, and the ROB target.
- Holds the instruction while the selected reservation station is full, and back-pressures decode.
- Snoops the writeback broadcast so a held operand never misses its producer's result.

Parameters:
- EX_UNIT_NUM, 4, number of ex_unit codes; code ERR_UNIT is not a real unit.
- EX_UNIT_W, 2, ex_unit field width.
- OP_W, 6, op field width.
- TAG_W, 4, ROB tag width.
- DATA_W, 32, operand width.
- TAG_INVALID, 0, tag value meaning "value ready".
- ERR_UNIT, 0, ex_unit code for an illegal instruction; such entries are discarded.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rst_tag  input  1  synchronous flush; drops the held entry.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage accepts this cycle.
- in_ex_unit  input  EX_UNIT_W  target unit code.
- in_op  input  OP_W  operation.
- in_tag1, in_tag2  input  TAG_W  source tags.
- in_val1, in_val2  input  DATA_W  source values.
- in_target  input  TAG_W  ROB slot of the destination.
- wb_valid  input  1  writeback broadcast valid.
- wb_tag  input  TAG_W  broadcast tag.
- wb_val  input  DATA_W  broadcast value.
- reservation_full  input  EX_UNIT_NUM  per-unit full flags.
- rs_valid  output  EX_UNIT_NUM  one-hot dispatch strobe.
- rs_op  output  OP_W  op of the held entry.
- rs_tag1, rs_tag2  output  TAG_W  held tags.
- rs_val1, rs_val2  output  DATA_W  held values.
- rs_target  output  TAG_W  held ROB target.
- stall_id  output  1  equals ~in_ready.

Behaviour:
- State is a single entry: valid_q plus ex_unit, op, tag1/2, val1/2 and target registers.
- Reset (asynchronous, rst=1): all registers 0, valid_q=0, rs_valid=0, in_ready=1, stall_id=0. Data outputs read 0.
- Dispatch:
  - fire = valid_q && !reservation_full[ex_unit_q].
  - rs_valid[ex_unit_q] = fire, combinational from registers. All other bits are 0.
  - Data outputs are driven directly from the registers.
- Accept:
  - in_ready = !valid_q || fire.
  - The entry loads on the clock edge when in_valid && in_ready && in_ex_unit != ERR_UNIT.
  - Latency is 1 cycle: data captured at edge N can be dispatched in cycle N+1.
- ERR_UNIT: the instruction is accepted (in_ready unaffected) but not loaded. If fire occurs in the same cycle, valid_q goes to 0.
- Fire without a new load: valid_q goes to 0 at the edge.
- Fire together with a new load: the new entry replaces the old one and valid_q stays 1. This gives back-to-back throughput of 1 instruction per cycle.
- Hold: if valid_q && !fire, all fields keep their values except for the wakeup below.
- Wakeup on the held entry:
  - If wb_valid && tag_i_q != TAG_INVALID && tag_i_q == wb_tag, then val_i_q <= wb_val and tag_i_q <= TAG_INVALID. Applies to i = 1, 2 independently; both may match the same broadcast.
  - Wakeup is not applied to an entry being dispatched this cycle; the reservation station snoops the same broadcast.
- wb_tag == TAG_INVALID never matches.
- Flush (rst_tag=1 at an edge): valid_q <= 0, and any load that cycle is suppressed.
  - Flush wins over load and wakeup.
  - rs_valid may still be high in the flush cycle itself; the reservation station also observes rst_tag.
- Reset asserted mid-hold: the entry is discarded immediately and asynchronously.

Optional Feature:
- Macro: IDEX_CAPTURE_SNOOP_EN.
- Defined: wakeup matching is also applied to the incoming in_tag1/in_tag2 on a load edge. A matching source loads wb_val with tag TAG_INVALID, which closes the window where decode read a tag that retires in that same cycle.
- Undefined: incoming fields are loaded verbatim, and wakeup applies only to an entry already held.

Test Plan:
- Reset then single instruction: in_valid=1, ex_unit=2, op=5, tag1=0, val1=7, tag2=3, target=9, reservation_full=0. Next cycle rs_valid=4'b0100, rs_val1=7, rs_tag2=3, rs_target=9. The following cycle rs_valid=0.
- Back-pressure: reservation_full[2]=1 for 3 cycles with the entry held. stall_id=1 and in_ready=0 throughout, and no rs_valid. When full drops, dispatch occurs in that same cycle and in_ready=1.
- Wakeup while held: held tag1=3; pulse wb_valid=1, wb_tag=3, wb_val=0xDEAD. Next cycle rs_tag1=0, rs_val1=0xDEAD, and tag2 is unaffected.
- Flush and ERR_UNIT:
  - Held entry plus rst_tag=1 gives rs_valid=0 the next cycle.
  - in_ex_unit=0 (ERR) gives in_ready=1 and nothing is dispatched.
- Throughput: 4 consecutive instructions with no full flags. One rs_valid pulse per cycle, in order; stall_id stays 0.
- Capture snoop (macro defined): in_tag2=5 while wb_valid=1, wb_tag=5, wb_val=0x11. Next cycle rs_tag2=0, rs_val2=0x11. With the macro undefined: rs_tag2=5.

Source files
------------

// File: rtl/idex_dispatch.sv
// ID/EX dispatch stage: a single-entry holding register between decode and
// the per-unit reservation stations. The entry is offered to the unit named
// by its ex_unit field and held while that unit is full. Decode sees this as
// back-pressure. While an entry is held, it snoops the writeback bus so that
// a waiting operand picks up its producer's result.
// Optional feature: define IDEX_CAPTURE_SNOOP_EN to apply the same writeback
// match to the incoming source tags on the load edge.
module idex_dispatch #(
   parameter int EX_UNIT_NUM = 4,
   parameter int EX_UNIT_W   = 2,
   parameter int OP_W        = 6,
   parameter int TAG_W       = 4,
   parameter int DATA_W      = 32,
   parameter int TAG_INVALID = 0,
   parameter int ERR_UNIT    = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rst_tag,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EX_UNIT_W-1:0]   in_ex_unit,
   input  logic [OP_W-1:0]        in_op,
   input  logic [TAG_W-1:0]       in_tag1,
   input  logic [TAG_W-1:0]       in_tag2,
   input  logic [DATA_W-1:0]      in_val1,
   input  logic [DATA_W-1:0]      in_val2,
   input  logic [TAG_W-1:0]       in_target,
   input  logic                   wb_valid,
   input  logic [TAG_W-1:0]       wb_tag,
   input  logic [DATA_W-1:0]      wb_val,
   input  logic [EX_UNIT_NUM-1:0] reservation_full,
   output logic [EX_UNIT_NUM-1:0] rs_valid,
   output logic [OP_W-1:0]        rs_op,
   output logic [TAG_W-1:0]       rs_tag1,
   output logic [TAG_W-1:0]       rs_tag2,
   output logic [DATA_W-1:0]      rs_val1,
   output logic [DATA_W-1:0]      rs_val2,
   output logic [TAG_W-1:0]       rs_target,
   output logic                   stall_id
);

   localparam logic [TAG_W-1:0]     TAG_NONE = TAG_W'(TAG_INVALID);
   localparam logic [EX_UNIT_W-1:0] UNIT_ERR = EX_UNIT_W'(ERR_UNIT);

   typedef struct packed {
      logic [EX_UNIT_W-1:0] ex_unit;
      logic [OP_W-1:0]      op;
      logic [TAG_W-1:0]     tag1;
      logic [DATA_W-1:0]    val1;
      logic [TAG_W-1:0]     tag2;
      logic [DATA_W-1:0]    val2;
      logic [TAG_W-1:0]     target;
   } entry_t;

   entry_t ent_q;
   entry_t in_ent;
   logic   valid_q;
   logic   fire;
   logic   load;
   logic   wb_live;
   logic   hit1;
   logic   hit2;

   // A broadcast of the "ready" tag is never a real producer.
   assign wb_live = wb_valid && (wb_tag != TAG_NONE);
   assign hit1    = wb_live && (ent_q.tag1 != TAG_NONE) && (ent_q.tag1 == wb_tag);
   assign hit2    = wb_live && (ent_q.tag2 != TAG_NONE) && (ent_q.tag2 == wb_tag);

   assign fire     = valid_q && !reservation_full[ent_q.ex_unit];
   assign in_ready = !valid_q || fire;
   assign stall_id = !in_ready;
   // ERR_UNIT instructions are accepted so that decode moves on, but they never occupy the entry.
   assign load     = in_valid && in_ready && (in_ex_unit != UNIT_ERR) && !rst_tag;

   assign rs_op     = ent_q.op;
   assign rs_tag1   = ent_q.tag1;
   assign rs_tag2   = ent_q.tag2;
   assign rs_val1   = ent_q.val1;
   assign rs_val2   = ent_q.val2;
   assign rs_target = ent_q.target;

   // One-hot dispatch strobe toward the unit selected by the held entry.
   always_comb begin
      rs_valid = '0;
      if (fire) rs_valid[ent_q.ex_unit] = 1'b1;
   end

   // Incoming entry, optionally woken by a broadcast in the same cycle.
   always_comb begin
      in_ent.ex_unit = in_ex_unit;
      in_ent.op      = in_op;
      in_ent.tag1    = in_tag1;
      in_ent.val1    = in_val1;
      in_ent.tag2    = in_tag2;
      in_ent.val2    = in_val2;
      in_ent.target  = in_target;
`ifdef IDEX_CAPTURE_SNOOP_EN
      if (wb_live && (in_tag1 == wb_tag)) begin
         in_ent.tag1 = TAG_NONE;
         in_ent.val1 = wb_val;
      end
      if (wb_live && (in_tag2 == wb_tag)) begin
         in_ent.tag2 = TAG_NONE;
         in_ent.val2 = wb_val;
      end
`endif
   end

   // Entry state: flush beats load, load replaces or refills, fire empties, and a held entry wakes up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ent_q   <= '0;
      end else if (rst_tag) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         ent_q   <= in_ent;
      end else if (fire) begin
         valid_q <= 1'b0;
      end else if (valid_q) begin
         // The reservation station snoops the same broadcast, so wakeup only matters while holding.
         if (hit1) begin
            ent_q.tag1 <= TAG_NONE;
            ent_q.val1 <= wb_val;
         end
         if (hit2) begin
            ent_q.tag2 <= TAG_NONE;
            ent_q.val2 <= wb_val;
         end
      end
   end

endmodule

// File: tb/tb_idex_dispatch.sv
// Self-checking bench for idex_dispatch: directed scenarios followed by random
// traffic. All traffic is compared against a queue-based reference model.
module tb_idex_dispatch;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst_tag;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_ex_unit;
   logic [5:0]  in_op;
   logic [3:0]  in_tag1, in_tag2, in_target;
   logic [31:0] in_val1, in_val2;
   logic        wb_valid;
   logic [3:0]  wb_tag;
   logic [31:0] wb_val;
   logic [3:0]  reservation_full;
   logic [3:0]  rs_valid;
   logic [5:0]  rs_op;
   logic [3:0]  rs_tag1, rs_tag2, rs_target;
   logic [31:0] rs_val1, rs_val2;
   logic        stall_id;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [1:0]  unit;
      logic [5:0]  op;
      logic [3:0]  t1, t2, tgt;
      logic [31:0] v1, v2;
   } ent_t;

   // Instructions waiting in the stage, oldest first (at most one).
   ent_t q[$];

   idex_dispatch dut (
      .clk(clk), .rst(rst), .rst_tag(rst_tag),
      .in_valid(in_valid), .in_ready(in_ready), .in_ex_unit(in_ex_unit), .in_op(in_op),
      .in_tag1(in_tag1), .in_tag2(in_tag2), .in_val1(in_val1), .in_val2(in_val2),
      .in_target(in_target), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
      .reservation_full(reservation_full), .rs_valid(rs_valid), .rs_op(rs_op),
      .rs_tag1(rs_tag1), .rs_tag2(rs_tag2), .rs_val1(rs_val1), .rs_val2(rs_val2),
      .rs_target(rs_target), .stall_id(stall_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [1:0] u, input logic [5:0] op,
                         input logic [3:0] t1, input logic [31:0] v1,
                         input logic [3:0] t2, input logic [31:0] v2, input logic [3:0] tgt);
      in_valid = v; in_ex_unit = u; in_op = op;
      in_tag1 = t1; in_val1 = v1; in_tag2 = t2; in_val2 = v2; in_target = tgt;
   endtask

   // Called at posedge+1: compare against the model, advance the model, clock.
   task automatic step();
      bit   held, fire, ready;
      logic [3:0] exp_rv;
      ent_t e;
      #2;
      held   = q.size() != 0;
      fire   = held && !reservation_full[q[0].unit];
      ready  = !held || fire;
      exp_rv = fire ? (4'b0001 << q[0].unit) : 4'b0000;
      chk("in_ready", 128'(in_ready), 128'(ready));
      chk("stall_id", 128'(stall_id), 128'(!ready));
      chk("rs_valid", 128'(rs_valid), 128'(exp_rv));
      if (held)
         chk("rs_data", {rs_op, rs_tag1, rs_val1, rs_tag2, rs_val2, rs_target},
                        {q[0].op, q[0].t1, q[0].v1, q[0].t2, q[0].v2, q[0].tgt});
      if (rst_tag) q.delete();
      else begin
         if (fire) void'(q.pop_front());
         else if (held) begin
            e = q[0];
            if (wb_valid && wb_tag != 0 && e.t1 == wb_tag) begin e.t1 = 0; e.v1 = wb_val; end
            if (wb_valid && wb_tag != 0 && e.t2 == wb_tag) begin e.t2 = 0; e.v2 = wb_val; end
            q[0] = e;
         end
         if (in_valid && ready && in_ex_unit != 2'd0) begin
            e = '{in_ex_unit, in_op, in_tag1, in_tag2, in_target, in_val1, in_val2};
`ifdef IDEX_CAPTURE_SNOOP_EN
            if (wb_valid && wb_tag != 0 && e.t1 == wb_tag) begin e.t1 = 0; e.v1 = wb_val; end
            if (wb_valid && wb_tag != 0 && e.t2 == wb_tag) begin e.t2 = 0; e.v2 = wb_val; end
`endif
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] units [4];
      units = '{2'd1, 2'd2, 2'd3, 2'd1};

      // Reset state
      rst = 1'b1; rst_tag = 1'b0;
      set_in(1'b0, 2'd0, 6'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0);
      wb_valid = 1'b0; wb_tag = 4'd0; wb_val = 32'd0; reservation_full = 4'd0;
      @(posedge clk); #3;
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_stall", 128'(stall_id), 128'(1'b0));
      chk("rst_rs_valid", 128'(rs_valid), 128'(4'b0));
      chk("rst_data", {rs_op, rs_tag1, rs_val1, rs_tag2, rs_val2, rs_target}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single instruction, one-cycle latency
      set_in(1'b1, 2'd2, 6'd5, 4'd0, 32'd7, 4'd3, 32'd0, 4'd9);
      step();
      in_valid = 1'b0; #1;
      chk("single_rv", 128'(rs_valid), 128'(4'b0100));
      chk("single_val1", 128'(rs_val1), 128'(32'd7));
      chk("single_tag2", 128'(rs_tag2), 128'(4'd3));
      chk("single_tgt", 128'(rs_target), 128'(4'd9));
      step(); #1;
      chk("single_done", 128'(rs_valid), 128'(4'b0));

      // Back-pressure: unit 2 full for three cycles while decode keeps offering
      set_in(1'b1, 2'd2, 6'd11, 4'd1, 32'd1, 4'd2, 32'd2, 4'd4);
      reservation_full = 4'b0100;
      step();
      set_in(1'b1, 2'd3, 6'd12, 4'd0, 32'd5, 4'd0, 32'd6, 4'd7);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_stall", 128'(stall_id), 128'(1'b1));
         chk("bp_ready", 128'(in_ready), 128'(1'b0));
         chk("bp_rv", 128'(rs_valid), 128'(4'b0));
         step();
      end
      reservation_full = 4'b0; in_valid = 1'b0; #1;
      chk("bp_release_rv", 128'(rs_valid), 128'(4'b0100));
      chk("bp_release_ready", 128'(in_ready), 128'(1'b1));
      chk("bp_release_op", 128'(rs_op), 128'(6'd11));
      step();

      // Wakeup while held
      set_in(1'b1, 2'd1, 6'd20, 4'd3, 32'd0, 4'd6, 32'd0, 4'd8);
      reservation_full = 4'b0010;
      step();
      in_valid = 1'b0; wb_valid = 1'b1; wb_tag = 4'd3; wb_val = 32'hDEAD;
      step();
      wb_valid = 1'b0; #1;
      chk("wake_tag1", 128'(rs_tag1), 128'(4'd0));
      chk("wake_val1", 128'(rs_val1), 128'(32'hDEAD));
      chk("wake_tag2", 128'(rs_tag2), 128'(4'd6));
      reservation_full = 4'b0;
      step();

      // Flush of a held entry
      set_in(1'b1, 2'd3, 6'd21, 4'd0, 32'd1, 4'd0, 32'd2, 4'd1);
      reservation_full = 4'b1000;
      step();
      in_valid = 1'b0; rst_tag = 1'b1;
      step();
      rst_tag = 1'b0; reservation_full = 4'b0; #1;
      chk("flush_rv", 128'(rs_valid), 128'(4'b0));
      chk("flush_ready", 128'(in_ready), 128'(1'b1));

      // ERR_UNIT is accepted but never dispatched
      set_in(1'b1, 2'd0, 6'd22, 4'd0, 32'd1, 4'd0, 32'd2, 4'd2);
      #1;
      chk("err_ready", 128'(in_ready), 128'(1'b1));
      step();
      in_valid = 1'b0; #1;
      chk("err_rv", 128'(rs_valid), 128'(4'b0));
      step();

      // Throughput: four back-to-back instructions
      for (int i = 0; i < 5; i++) begin
         if (i < 4) set_in(1'b1, units[i], 6'(30 + i), 4'd0, 32'(i), 4'd0, 32'(i), 4'(i));
         else in_valid = 1'b0;
         #1;
         if (i > 0) chk("tput_rv", 128'(rs_valid), 128'(4'b0001 << units[i-1]));
         chk("tput_stall", 128'(stall_id), 128'(1'b0));
         step();
      end

      // Capture snoop: source tag retiring on the load edge
      set_in(1'b1, 2'd3, 6'd40, 4'd0, 32'd3, 4'd5, 32'h22, 4'd6);
      wb_valid = 1'b1; wb_tag = 4'd5; wb_val = 32'h11;
      step();
      in_valid = 1'b0; wb_valid = 1'b0; #1;
`ifdef IDEX_CAPTURE_SNOOP_EN
      chk("snoop_tag2", 128'(rs_tag2), 128'(4'd0));
      chk("snoop_val2", 128'(rs_val2), 128'(32'h11));
`else
      chk("snoop_tag2", 128'(rs_tag2), 128'(4'd5));
      chk("snoop_val2", 128'(rs_val2), 128'(32'h22));
`endif
      step();

      // Asynchronous reset in the middle of a hold
      set_in(1'b1, 2'd2, 6'd50, 4'd1, 32'd9, 4'd2, 32'd8, 4'd3);
      reservation_full = 4'b0100;
      step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_rv", 128'(rs_valid), 128'(4'b0));
      chk("arst_ready", 128'(in_ready), 128'(1'b1));
      chk("arst_op", 128'(rs_op), 128'(6'd0));
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0; reservation_full = 4'b0;

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 6'($urandom),
                4'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 3)), $urandom,
                4'($urandom));
         wb_valid = $urandom_range(0, 1) != 0;
         wb_tag   = 4'($urandom_range(0, 3));
         wb_val   = $urandom;
         reservation_full = 4'($urandom) & 4'($urandom);
         rst_tag  = $urandom_range(0, 19) == 0;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
